// File: rtl/dsp_mac_pipe_pkg.sv
// Shared types and constants for the pipelined multiply-accumulate element.
// The multiplier columns of the multi-precision datapath import this package.
package dsp_mac_pipe_pkg;

    typedef enum logic [1:0] {
        MUL     = 2'd0,
        MULADD  = 2'd1,
        PE      = 2'd2,
        ACC_SHR = 2'd3
    } mac_mode_t;

    localparam int DSP_P_W = 48;

endpackage

// File: rtl/dsp_mac_pipe_stage.sv
// Pipeline register with a travelling valid bit and synchronous active-low clear.
// The data register only loads on valid, so bubbles do not toggle the payload.
module mac_pipe_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Pipelined unsigned multiply-accumulate element: MUL, MULADD, dual-product PE
// and shifting column accumulation, with a valid bit travelling beside the data.
module dsp_mac_pipe
    import dsp_mac_pipe_pkg::*;
#(
    parameter int A_W = 16,
    parameter int B_W = 16,
    parameter int LAT = 2,
    parameter int SHR = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  mac_mode_t          in_mode,
    input  logic               in_first,
    input  logic [A_W-1:0]     in_a,
    input  logic [A_W-1:0]     in_m,
    input  logic [B_W-1:0]     in_b,
    input  logic [B_W-1:0]     in_q,
    input  logic [DSP_P_W-1:0] in_s,
    output logic               out_valid,
    output logic [DSP_P_W-1:0] out_s,
    output logic [SHR-1:0]     out_lo
);

    generate
        if (LAT < 1 || LAT > 4) begin : g_bad_lat
            $error("dsp_mac_pipe: LAT must be in 1..4");
        end
        if (A_W > 27 || B_W > 18) begin : g_bad_width
            $error("dsp_mac_pipe: A_W must be <= 27 and B_W <= 18");
        end
        if (SHR < 1 || SHR > 47) begin : g_bad_shr
            $error("dsp_mac_pipe: SHR must be in 1..47");
        end
    endgenerate

    // LAT=4 adds a second operand register ahead of the product register
    localparam int N_IN = (LAT == 4) ? 2 : ((LAT >= 2) ? 1 : 0);

    typedef struct packed {
        mac_mode_t          mode;
        logic               first;
        logic [A_W-1:0]     a;
        logic [A_W-1:0]     m;
        logic [B_W-1:0]     b;
        logic [B_W-1:0]     q;
        logic [DSP_P_W-1:0] s;
    } opnd_t;

    typedef struct packed {
        mac_mode_t          mode;
        logic               first;
        logic [DSP_P_W-1:0] p_ab;
        logic [DSP_P_W-1:0] p_qm;
        logic [DSP_P_W-1:0] s;
    } prod_t;

    opnd_t opnd_d [N_IN+1];
    logic  opnd_v [N_IN+1];

    assign opnd_v[0] = in_valid;
    assign opnd_d[0] = '{mode: in_mode, first: in_first, a: in_a, m: in_m,
                         b: in_b, q: in_q, s: in_s};

    generate
        for (genvar i = 0; i < N_IN; i++) begin : g_opnd
            mac_pipe_stage #(.W($bits(opnd_t))) u_opnd (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_valid (opnd_v[i]),
                .in_data  (opnd_d[i]),
                .out_valid(opnd_v[i+1]),
                .out_data (opnd_d[i+1])
            );
        end
    endgenerate

    prod_t prod_c;
    prod_t prod_d;
    logic  prod_v;

    always_comb begin
        prod_c.mode  = opnd_d[N_IN].mode;
        prod_c.first = opnd_d[N_IN].first;
        prod_c.p_ab  = DSP_P_W'(opnd_d[N_IN].a) * DSP_P_W'(opnd_d[N_IN].b);
        prod_c.p_qm  = DSP_P_W'(opnd_d[N_IN].q) * DSP_P_W'(opnd_d[N_IN].m);
        prod_c.s     = opnd_d[N_IN].s;
    end

    generate
        if (LAT >= 3) begin : g_prod_reg
            mac_pipe_stage #(.W($bits(prod_t))) u_prod (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_valid (opnd_v[N_IN]),
                .in_data  (prod_c),
                .out_valid(prod_v),
                .out_data (prod_d)
            );
        end else begin : g_prod_comb
            assign prod_v = opnd_v[N_IN];
            assign prod_d = prod_c;
        end
    endgenerate

    logic [DSP_P_W-1:0] acc;
    logic [DSP_P_W-1:0] addend;
    logic [DSP_P_W-1:0] qm_term;
    logic [DSP_P_W-1:0] r;

    // acc feedback stays inside the final stage so ACC_SHR streams at full rate
    always_comb begin
        addend  = prod_d.s;
        qm_term = '0;
        case (prod_d.mode)
            MUL: addend = '0;
            PE:  qm_term = prod_d.p_qm;
            ACC_SHR: begin
                qm_term = prod_d.p_qm;
                if (!prod_d.first) begin
                    addend = acc >> SHR;
                end
            end
            default: ;
        endcase
        r = prod_d.p_ab + qm_term + addend;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_s     <= '0;
            acc       <= '0;
        end else begin
            out_valid <= prod_v;
            if (prod_v) begin
                out_s <= r;
                if (prod_d.mode == ACC_SHR) begin
                    acc <= r;
                end
            end
        end
    end

    assign out_lo = out_s[SHR-1:0];

endmodule

// File: doc/dsp_mac_pipe.md
# dsp_mac_pipe

Parametrised, pipelined multiply-accumulate processing element. It is the generic successor to the fixed-latency 16×16 PE / muladd / mul DSP wrappers. A per-transaction mode selects plain multiply, multiply-add, dual-product Montgomery PE, or shifting column accumulation, and a valid signal travels alongside the data. It sits in the BN254 multi-precision datapath, where multiplier columns instantiate it in place of separate DSP wrappers.

## Interface
- `A_W`, default 16: width of `in_a`/`in_m`; must be ≤ 27.
- `B_W`, default 16: width of `in_b`/`in_q`; must be ≤ 18.
- `LAT`, default 2: cycles from input to output, range 1..4. Any other value is an elaboration error.
- `SHR`, default 16: right-shift applied to the accumulator in ACC_SHR mode; range 1..47.
- `clk` in 1: the only clock; all logic is on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: the transaction on the inputs is valid this cycle.
- `in_mode` in 2: `mac_mode_t` value, one of MUL=0, MULADD=1, PE=2, ACC_SHR=3.
- `in_first` in 1: ACC_SHR only; marks the first term, which loads the accumulator from `in_s`.
- `in_a`, `in_m` in A_W: multiplicands, unsigned.
- `in_b`, `in_q` in B_W: multipliers, unsigned.
- `in_s` in 48: addend, or the accumulator seed.
- `out_valid` out 1: `out_s` is valid.
- `out_s` out 48: result.
- `out_lo` out SHR: `out_s[SHR-1:0]`, the column digit.

## Operation
- All arithmetic is unsigned, modulo 2^48, with no overflow flag. Products are zero-extended to 48 bits.
- Result `r` by mode:
  - MUL: r = a·b.
  - MULADD: r = a·b + s.
  - PE: r = a·b + q·m + s.
  - ACC_SHR: r = (in_first ? s : (acc >> SHR)) + a·b + q·m.
- The mode, `in_first` and the operands travel together down the pipeline. Mode may change every cycle; there is no drain requirement.
- `acc` is an internal 48-bit register. It updates only when a valid ACC_SHR transaction reaches the final stage, and then takes the value `r`. Other modes leave `acc` unchanged.
- `out_s` and `out_lo` update only on a valid final stage and otherwise hold their last value.
- Back-to-back ACC_SHR transactions are supported at one per cycle. The feedback path `acc`→`r` lies entirely within the final stage.
- An ACC_SHR transaction with `in_first`=0 after reset uses `acc`=0.
- There is no backpressure. Every accepted input produces exactly one output.
- Invalid cycles propagate as bubbles and have no side effects.

## Timing
- Latency: an input accepted at cycle t appears with `out_valid`=1 at cycle t+LAT.
- Throughput is one transaction per cycle.
- Stage layout:
  - LAT=1: only the final register (products and sum in a single stage).
  - LAT=2: input registers, then the final register.
  - LAT=3: input registers, product registers, final register.
  - LAT=4: as LAT=3 plus a second input register.
- Reset (`rst_n`=0 at an edge):
  - On the next edge, every valid stage, `out_valid`, `out_s`, `out_lo` and `acc` become 0.
  - Transactions in flight are discarded without output.
  - Inputs presented while `rst_n`=0 are ignored.
  - The first input accepted is the one at the first edge with `rst_n`=1.
- Simultaneous events: a valid final-stage ACC_SHR update and a fresh `in_first` in the input stage do not interact. `in_first` acts only when its own transaction reaches the final stage.

## Structure
- The shared package `PARAMS_BN254_16_16` gains:
  - `typedef enum logic [1:0] {MUL, MULADD, PE, ACC_SHR} mac_mode_t`
  - `localparam int DSP_P_W = 48`
- Existing K/L constants feed `B_W`/`A_W` at instantiation.
- One sub-module, `mac_pipe_stage`: a parametrised-width register with valid and synchronous active-low clear. It is instantiated per stage through a generate loop over LAT. The top level holds only the product/sum logic and `acc`.
- Implementation is behavioural RTL inferable onto two cascaded DSP48E2 slices, with no IP cores.

## Test plan
- **MUL:** LAT=2, MUL, a=0xFFFF, b=0xFFFF → out_s=0xFFFE0001 exactly 2 cycles later; out_valid is high for 1 cycle.
- **PE wrap:** PE, a=b=q=m=0xFFFF, s=0xFFFFFFFFFFFF → out_s=0x0001FFFC0001 (mod 2^48).
- **ACC_SHR stream:** SHR=16. Send 3 consecutive transactions with a=2, b=3, q=m=0, first with in_first=1 and s=0x10000 → out_s = 0x10006, then 0x7, then 0x6, with out_lo = 0x0006, 0x0007, 0x0006.
- **Mixed modes:** alternate MUL and ACC_SHR every cycle with bubbles in between → outputs stay in order, acc is affected only by ACC_SHR, and no out_valid appears for bubbles.
- **Reset mid-flight:** LAT=4, 3 transactions in flight, rst_n=0 for 1 cycle → none of them is output; all outputs are 0; the next ACC_SHR with in_first=0, a=1, b=1 gives out_s=1.
- **Latency sweep:** LAT=1..4 with a random 1000-transaction stream checked against a reference model → bit-exact, with latency equal to LAT.
